// File: rtl/boot_loader_if.sv
// Boot loader bus: byte stream and start on the host side,
// word commits and status on the memory side.
interface boot_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        debug;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic        boot_we;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, rx_data, rx_valid,
        input  debug, boot_addr, boot_data, boot_we,
        input  busy, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output debug, boot_addr, boot_data, boot_we,
        output busy, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Serial image loader: 16-bit word count, little-endian words, one commit each.
// Define BOOT_LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module boot_loader #(
    parameter int MAX_WORDS = 8192
) (
    input logic         clk,
    input logic         rst_n,
    boot_loader_if.slave bus
);

`ifdef BOOT_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, COMMIT, CHK, DONE, ERR
    } state_t;
    localparam state_t TAIL = CHK;
`else
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, COMMIT, DONE, ERR
    } state_t;
    localparam state_t TAIL = DONE;
`endif

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [31:0] shadow_q;
    logic [1:0]  byte_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic        debug_q;
    logic [15:0] len_w;
    logic        more;
    logic        take;
    logic        fire;
    logic        start_ok;
`ifdef BOOT_LOADER_CHKSUM_EN
    logic [7:0]  xor_q;
    logic        chk_ok;

    assign chk_ok = (bus.rx_data == xor_q);
`endif

    assign len_w    = {bus.rx_data, len_q[7:0]};
    assign more     = (idx_q < len_q);
    // A byte landing in the commit cycle starts the next word
    assign take     = bus.rx_valid &&
                      (state_q == DATA ||
                       (state_q == COMMIT && more));
    assign fire     = take && (byte_q == 2'd3);
    assign start_ok = bus.start &&
                      (state_q == IDLE ||
                       state_q == DONE ||
                       state_q == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (bus.rx_valid) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (bus.rx_valid) begin
                    if ({1'b0, len_w} > MAX_N)
                        state_d = ERR;
                    else if (len_w == 16'd0)
                        state_d = TAIL;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (fire) state_d = COMMIT;
            end
            COMMIT: begin
                if (more) begin
                    state_d = DATA;
                end else begin
`ifdef BOOT_LOADER_CHKSUM_EN
                    if (bus.rx_valid)
                        state_d = chk_ok ? DONE : ERR;
                    else
                        state_d = CHK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef BOOT_LOADER_CHKSUM_EN
            CHK: begin
                if (bus.rx_valid)
                    state_d = chk_ok ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (bus.start) state_d = LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            byte_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            debug_q  <= 1'b0;
`ifdef BOOT_LOADER_CHKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (state_d == DONE || state_d == ERR)
                debug_q <= 1'b0;
            if (start_ok) begin
                idx_q  <= '0;
                byte_q <= '0;
`ifdef BOOT_LOADER_CHKSUM_EN
                xor_q  <= '0;
`endif
            end
            if (state_q == LEN_LO && bus.rx_valid)
                len_q[7:0] <= bus.rx_data;
            if (state_q == LEN_HI && bus.rx_valid)
                len_q[15:8] <= bus.rx_data;
            if (take) begin
                shadow_q[{byte_q, 3'b000} +: 8] <= bus.rx_data;
                byte_q <= byte_q + 2'd1;
`ifdef BOOT_LOADER_CHKSUM_EN
                xor_q  <= xor_q ^ bus.rx_data;
`endif
            end
            // Address and data move only here, together with the strobe
            if (fire) begin
                data_q  <= {bus.rx_data, shadow_q[23:0]};
                addr_q  <= {16'd0, idx_q};
                idx_q   <= idx_q + 16'd1;
                we_q    <= 1'b1;
                debug_q <= 1'b1;
            end
        end
    end

    assign bus.boot_addr = addr_q;
    assign bus.boot_data = data_q;
    assign bus.boot_we   = we_q;
    assign bus.debug     = debug_q;
    assign bus.busy      = !(state_q == IDLE ||
                             state_q == DONE ||
                             state_q == ERR);
    assign bus.done      = (state_q == DONE);
    assign bus.error     = (state_q == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: model queues commits, monitor pops them.
module tb_boot_loader;
    localparam int MAXW = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if bl();

    boot_loader #(.MAX_WORDS(MAXW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bl)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } commit_t;

    commit_t exp_q[$];
    commit_t mc;
    int      vectors = 0;
    int      miscompares = 0;
    bit      dbg_forbid = 1'b0;
    bit      exp_err;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bl.boot_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", 32'd1, 32'd0);
                end else begin
                    mc = exp_q.pop_front();
                    check("commit_addr", bl.boot_addr, mc.addr);
                    check("commit_data", bl.boot_data, mc.data);
                    check("commit_debug", {31'd0, bl.debug}, 32'd1);
                end
            end
            if (dbg_forbid)
                check("debug_low", {31'd0, bl.debug}, 32'd0);
        end
    end

    function automatic logic [7:0] xsum(input logic [7:0] bs[$]);
        logic [7:0] x = 8'h00;
        for (int i = 2; i < bs.size(); i++) x ^= bs[i];
        return x;
    endfunction

    task automatic seal(input logic [7:0] a[$], input bit bad,
                        output logic [7:0] b[$]);
        b = a;
`ifdef BOOT_LOADER_CHKSUM_EN
        b.push_back(xsum(a) ^ {7'd0, bad});
`endif
    endtask

    task automatic make_img(input int n, input bit bad,
                            output logic [7:0] bs[$]);
        logic [7:0] raw[$];
        raw.push_back(n[7:0]);
        raw.push_back(n[15:8]);
        if (n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) raw.push_back(8'($urandom));
            seal(raw, bad, bs);
        end else begin
            bs = raw;
        end
    endtask

    // Reference: words are consecutive little-endian groups of four bytes
    task automatic model(input logic [7:0] bs[$]);
        int n;
        commit_t c;
        n = {16'd0, bs[1], bs[0]};
        exp_err = 1'b0;
        if (n > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            c.addr = w;
            c.data = {bs[5+4*w], bs[4+4*w], bs[3+4*w], bs[2+4*w]};
            exp_q.push_back(c);
        end
`ifdef BOOT_LOADER_CHKSUM_EN
        exp_err = (bs[2+4*n] != xsum(bs[0:1+4*n]));
`endif
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bl.rx_data  = b;
        bl.rx_valid = 1'b1;
        @(negedge clk);
        bl.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bl.start = 1'b1;
        @(negedge clk);
        bl.start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] bs[$], input int maxgap);
        int n;
        int t;
        n = {16'd0, bs[1], bs[0]};
        model(bs);
        dbg_forbid = (n == 0 || n > MAXW);
        pulse_start();
        check("busy", {31'd0, bl.busy}, 32'd1);
        foreach (bs[i]) send(bs[i], int'($urandom_range(maxgap, 0)));
        t = 0;
        while (!(bl.done || bl.error) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("end_timeout", {31'd0, t < 40}, 32'd1);
        check("done", {31'd0, bl.done}, {31'd0, !exp_err});
        check("error", {31'd0, bl.error}, {31'd0, exp_err});
        check("debug_end", {31'd0, bl.debug}, 32'd0);
        check("commits_left", exp_q.size(), 32'd0);
        exp_q.delete();
        dbg_forbid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, bl.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bl.done}, 32'd0);
        check({tag, "_error"}, {31'd0, bl.error}, 32'd0);
        check({tag, "_debug"}, {31'd0, bl.debug}, 32'd0);
        check({tag, "_we"}, {31'd0, bl.boot_we}, 32'd0);
        check({tag, "_addr"}, bl.boot_addr, 32'd0);
        check({tag, "_data"}, bl.boot_data, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] bs[$];
        logic [7:0] raw[$];
        int n;
        bl.start    = 1'b0;
        bl.rx_data  = 8'h00;
        bl.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        raw = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAA, 8'hBB, 8'hCC, 8'hDD};
        seal(raw, 1'b0, bs);
        run_load(bs, 2);

        raw = '{8'h00, 8'h00};
        seal(raw, 1'b0, bs);
        run_load(bs, 1);

        bs = '{8'h01, 8'h21};
        run_load(bs, 1);

        bs = '{8'h01, 8'h20};
        run_load(bs, 0);

        make_img(3, 1'b0, bs);
        run_load(bs, 0);

        // Mid-load reset after the fifth data byte of a two-word image
        make_img(2, 1'b0, bs);
        model(bs);
        pulse_start();
        for (int i = 0; i < 7; i++) send(bs[i], 0);
        check("pre_reset_commits", exp_q.size(), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        make_img(2, 1'b0, bs);
        run_load(bs, 1);

        for (int k = 0; k < 14; k++) begin
            n = int'($urandom_range(6, 0));
            if ($urandom_range(5, 0) == 0)
                n = int'($urandom_range(65535, MAXW + 1));
            make_img(n, 1'($urandom_range(1, 0)), bs);
            run_load(bs, int'($urandom_range(3, 0)));
        end

`ifdef BOOT_LOADER_CHKSUM_EN
        bs = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run_load(bs, 1);
        bs = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run_load(bs, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 8192, the maximum image length in 32-bit words (bank depth).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse requesting a new image load.
REQ-005 SHALL have port rx_data, input, 8, the received byte from the serial receiver.
REQ-006 SHALL have port rx_valid, input, 1, qualifying rx_data for exactly one cycle per byte.
REQ-007 SHALL have port debug, output, 1, the data-memory boot-write mode select.
REQ-008 SHALL have port boot_addr, output, 32, the word index of the committed word; the memory uses bits [12:0].
REQ-009 SHALL have port boot_data, output, 32, the committed word; byte lane k feeds bank k.
REQ-010 SHALL have port boot_we, output, 1, a one-cycle strobe marking each new commit.
REQ-011 SHALL have ports busy, done, and error, each output, 1, reporting status.

Function
REQ-012 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, COMMIT, CHK, DONE, and ERR.
REQ-013 SHALL move IDLE to LEN_LO on start, and SHALL ignore start in every other state except DONE and ERR, which also accept start and move to LEN_LO.
REQ-014 SHALL capture the first valid byte as len[7:0] and the second as len[15:8], forming a 16-bit word count N.
REQ-015 SHALL, when N==0, go directly to DONE, or to CHK when checksum is enabled, with no commit and with debug never asserted.
REQ-016 SHALL, when N>MAX_WORDS, enter ERR with error=1 and no commit.
REQ-017 SHALL, in DATA, assemble bytes little-endian into a shadow register: the first byte goes to [7:0] and the fourth byte to [31:24].
REQ-018 SHALL enter COMMIT for one cycle after the fourth byte, and in that cycle SHALL update boot_data=shadow and boot_addr=word index together, pulse boot_we=1, and set debug=1.
REQ-019 SHALL never change boot_addr or boot_data except in COMMIT, so that the memory can rewrite the held word idempotently while debug=1.
REQ-020 SHALL start the word index at 0 and increment it by 1 per commit, with no wrap; the index never exceeds MAX_WORDS-1 because of REQ-016.
REQ-021 SHALL return from COMMIT to DATA while the word index is below N, and otherwise go to DONE, or to CHK when checksum is enabled.
REQ-022 SHALL accept an rx_valid byte arriving in the COMMIT cycle into the shadow register, with no byte lost.
REQ-023 SHALL clear debug on entry to DONE or ERR, and SHALL hold done=1 in DONE and error=1 in ERR until the next start.
REQ-024 SHALL hold busy=1 in all states other than IDLE, DONE, and ERR.
REQ-025 SHALL ignore rx_valid in IDLE, DONE, and ERR.

Reset
REQ-026 SHALL, while rst_n=0, force state to IDLE and drive debug, boot_we, busy, done, and error to 0, boot_addr to 0, and boot_data to 0, asynchronously.
REQ-027 SHALL abort any load in progress on a mid-load reset; words already committed remain in memory, and no further commit occurs.

Configuration
REQ-028 SHALL, when BOOT_LOADER_CHKSUM_EN is defined, expect one trailing byte after the last data byte equal to the XOR of all data bytes; on a match it goes to DONE, and on a mismatch it goes to ERR with error=1.
REQ-029 SHALL, when BOOT_LOADER_CHKSUM_EN is undefined, omit the CHK state and the XOR accumulator and go from the final COMMIT directly to DONE.

Verification
REQ-030 SHALL pass this scenario: start, then bytes 02 00 11 22 33 44 AA BB CC DD -> commit addr 0 data 0x44332211 and commit addr 1 data 0xDDCCBBAA, two boot_we pulses, then done=1 and debug=0.
REQ-031 SHALL pass this scenario: start, then bytes 00 00 -> done=1, with debug and boot_we never asserted.
REQ-032 SHALL pass this scenario: start, then bytes 01 21, giving N=8449 which exceeds 8192 -> error=1 with no boot_we.
REQ-033 SHALL pass this scenario: assert rst_n=0 after the 5th data byte of an N=2 load -> all outputs 0 immediately, and after release a new start reloads from addr 0.
REQ-034 SHALL pass this scenario: back-to-back rx_valid every cycle, including the COMMIT cycle, with N=3 -> three correct commits with no dropped byte.
REQ-035 SHALL pass this scenario, only with BOOT_LOADER_CHKSUM_EN defined: N=1 with data 01 02 04 08 and checksum 0F -> done=1, and the same data with checksum 0E -> error=1.
